muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning the number of iterations per multiply or divide.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new operation this cycle.
REQ-005 SHALL have port op, input, 1 bit: 0 = MULTU, 1 = DIVU.
REQ-006 SHALL have port a, input, 32 bits: multiplicand or dividend (rs).
REQ-007 SHALL have port b, input, 32 bits: multiplier or divisor (rt).
REQ-008 SHALL have port hilo_rd, input, 1 bit: the decoded instruction is MFHI or MFLO.
REQ-009 SHALL have ports wr_hi and wr_lo, input, 1 bit each: MTHI or MTLO write enables.
REQ-010 SHALL have port wd, input, 32 bits: MTHI or MTLO data.
REQ-011 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO register contents.
REQ-012 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port stall, output, 1 bit: freeze PC and instruction fetch.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 Transitions SHALL be: IDLE or DONE with start goes to RUN; RUN with count==ITER-1 goes to DONE; DONE without start goes to IDLE.
REQ-017 Divide-by-zero (op=1, b==0) SHALL go from IDLE or DONE straight to DONE, bypassing RUN.
REQ-018 On start, the unit SHALL latch a, b and op, and clear count and the accumulators.
REQ-019 MULTU SHALL be a shift-add, one multiplier bit per RUN cycle, producing a 64-bit product with HI=[63:32] and LO=[31:0].
REQ-020 DIVU SHALL be restoring, one quotient bit per RUN cycle, with LO=quotient and HI=remainder.
REQ-021 Divide-by-zero SHALL write HI=a and LO=32'hFFFFFFFF.
REQ-022 HI/LO SHALL update only on the edge that enters DONE.
REQ-023 Latency SHALL be: start sampled at edge E0, done=1 during the cycle after edge E(ITER), i.e. 33 cycles for ITER=32.
REQ-024 Divide-by-zero latency SHALL be done=1 during the cycle after E0.
REQ-025 busy SHALL be 1 exactly while in RUN.
REQ-026 done SHALL be 1 exactly while in DONE.
REQ-027 start while busy SHALL be ignored: no relatch and no restart.
REQ-028 stall SHALL equal busy AND (start OR hilo_rd OR wr_hi OR wr_lo).
REQ-029 wr_hi and wr_lo SHALL write wd to HI or LO in IDLE or DONE, and SHALL be ignored while busy.
REQ-030 If wr_hi or wr_lo is asserted in the same cycle as start, the write SHALL occur and the operation's later result SHALL overwrite it.
REQ-031 Results SHALL be unsigned; all arithmetic width is 32 bits, with a 33-bit trial subtraction for divide.
REQ-032 count SHALL be $clog2(ITER) bits wide and SHALL NOT wrap inside RUN.

Reset
REQ-033 When rst=1 at an edge: state=IDLE, count=0, hi=0, lo=0, busy=0, done=0 and stall=0, overriding all other inputs.
REQ-034 Reset during RUN SHALL abandon the operation with no HI/LO update and no done pulse.

Structure
REQ-035 Package muldiv_pkg SHALL hold the state enum, the op encodings (OP_MULTU=0, OP_DIVU=1) and ITER_DEFAULT=32.
REQ-036 A combinational single-step sub-module muldiv_step SHALL compute one shift-add or restore iteration; the FSM, counter and HI/LO registers SHALL reside in muldiv_seq.

Verification
REQ-037 MULTU a=7, b=6 -> busy for 32 cycles; done in cycle 33; HI=0, LO=42.
REQ-038 MULTU a=FFFFFFFF, b=FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
REQ-039 DIVU a=100, b=7 -> LO=14, HI=2, done in cycle 33; DIVU a=5, b=0 -> done the cycle after start, HI=5, LO=FFFFFFFF, busy never 1.
REQ-040 Start MULTU 3*4, then assert start (DIVU 9/3) and hilo_rd at cycle 10 -> stall=1 that cycle; the divide is ignored; result HI=0, LO=12.
REQ-041 Back-to-back: start asserted during DONE -> the new op enters RUN with no IDLE cycle and the first result is retained until the second DONE.
REQ-042 Reset at cycle 10 of MULTU 7*6 after preloading HI=LO=5 via MTHI/MTLO -> next cycle busy=0, done=0, HI=0, LO=0, and no done pulse follows.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential HI/LO multiply/divide unit.
// No logic; pure declarations.
// No flow control.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_MULTU     = 1'b0;
    localparam logic OP_DIVU      = 1'b1;
    localparam int   ITER_DEFAULT = 32;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (MULTU) or restoring (DIVU) iteration on the {acc_hi, acc_lo} pair.
// Purely combinational, zero latency.
// No flow control; the caller decides when to register the result.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        op,
    input  logic [31:0] acc_hi,
    input  logic [31:0] acc_lo,
    input  logic [31:0] opnd,
    output logic [31:0] nxt_hi,
    output logic [31:0] nxt_lo
);

    logic [32:0] sum;
    logic [32:0] trial;

    // Multiply: conditionally add the multiplicand to the upper half, then shift
    // the 64-bit pair right. Divide: shift the pair left one bit and keep the
    // 33-bit trial difference only when it does not borrow.
    always_comb begin
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
        trial  = {acc_hi, acc_lo[31]} - {1'b0, opnd};
        nxt_hi = sum[32:1];
        nxt_lo = {sum[0], acc_lo[31:1]};
        if (op == OP_DIVU) begin
            if (!trial[32]) begin
                nxt_hi = trial[31:0];
                nxt_lo = {acc_lo[30:0], 1'b1};
            end else begin
                nxt_hi = {acc_hi[30:0], acc_lo[31]};
                nxt_lo = {acc_lo[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MULTU/DIVU unit owning the architectural HI/LO registers.
// Latency: ITER+1 cycles from start to the done pulse; divide-by-zero completes in 1.
// Backpressure: stall asserts while busy and the pipeline needs the unit or HI/LO.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_rd,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t        state;
    logic [CW-1:0] count;
    logic          op_q;
    logic [31:0]   opnd_q;
    logic [31:0]   acc_hi;
    logic [31:0]   acc_lo;
    logic [31:0]   step_hi;
    logic [31:0]   step_lo;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          div_zero;

    assign div_zero = (op == OP_DIVU) && (b == 32'd0);

    muldiv_step u_step (
        .op     (op_q),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opnd   (opnd_q),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    // Control FSM, iteration counter, accumulators and HI/LO. The accumulator
    // low half starts with the multiplier (MULTU) or dividend (DIVU); the other
    // operand is held in opnd_q for the whole run. HI/LO change only through
    // MTHI/MTLO when not busy, or on the edge that enters DONE, so a result
    // always lands after any MTHI/MTLO issued alongside its start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            op_q   <= OP_MULTU;
            opnd_q <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (wr_hi) hi_q <= wd;
                    if (wr_lo) lo_q <= wd;
                    if (start) begin
                        op_q   <= op;
                        count  <= '0;
                        acc_hi <= '0;
                        opnd_q <= (op == OP_MULTU) ? a : b;
                        acc_lo <= (op == OP_MULTU) ? b : a;
                        if (div_zero) begin
                            state <= ST_DONE;
                            hi_q  <= a;
                            lo_q  <= 32'hFFFF_FFFF;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (count == LAST) begin
                        state <= ST_DONE;
                        hi_q  <= step_hi;
                        lo_q  <= step_lo;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);
    assign stall = busy && (start || hilo_rd || wr_hi || wr_lo);

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed corner cases plus randomized ops.
// Expected results come from plain 64-bit arithmetic, / and %.
// A negedge monitor pops one expectation per done pulse.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int ITER = 32;

    logic        clk = 1'b0;
    logic        rst, start, op, hilo_rd, wr_hi, wr_lo;
    logic [31:0] a, b, wd, hi, lo;
    logic        busy, done, stall;

    always #5 clk = ~clk;

    muldiv_seq #(.ITER(ITER)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hilo_rd(hilo_rd), .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        int          busy_len;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: one expectation per done cycle, with latency and busy length.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done=1 with no pending operation (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
                check("done_cycle", cyc, e.cyc);
                check("busy_cycles", busy_cnt, e.busy_len);
                m_hi = e.hi;
                m_lo = e.lo;
            end
            busy_cnt = 0;
        end
    end

    // Reference model: plain unsigned arithmetic on the requested operation.
    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        if (o == OP_MULTU) begin
            p = {32'd0, x} * {32'd0, y};
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.busy_len = ITER;
            e.cyc = cyc + 1 + ITER;
        end else if (y == 32'd0) begin
            e.hi = x;
            e.lo = 32'hFFFF_FFFF;
            e.busy_len = 0;
            e.cyc = cyc + 1;
        end else begin
            e.hi = x % y;
            e.lo = x / y;
            e.busy_len = ITER;
            e.cyc = cyc + 1 + ITER;
        end
        sb.push_back(e);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", done, 1'b1);
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_hi", hi, m_hi);
        check("idle_lo", lo, m_lo);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(1, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        bit b2b;
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        hilo_rd = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        hilo_rd = 1'b1;
        #1 check("idle_stall", stall, 1'b0);
        hilo_rd = 1'b0;

        // Directed results
        issue(OP_MULTU, 32'd7, 32'd6);                 wait_done(); idle_check();
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(); idle_check();
        issue(OP_DIVU, 32'd100, 32'd7);                wait_done(); idle_check();
        issue(OP_DIVU, 32'd5, 32'd0);                  wait_done(); idle_check();

        // MTHI in idle
        @(negedge clk);
        wr_hi = 1'b1; wd = 32'hA5A5_0F0F; m_hi = wd;
        #1 check("mt_idle_stall", stall, 1'b0);
        @(negedge clk);
        wr_hi = 1'b0;
        check("mthi_hi", hi, m_hi);
        check("mthi_lo", lo, m_lo);

        // Start + MFHI while busy: stalled, divide ignored
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (8) @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3; hilo_rd = 1'b1;
        #1 check("busy_start_stall", stall, 1'b1);
        @(negedge clk);
        start = 1'b0; hilo_rd = 1'b0;
        wait_done(); idle_check();

        // MTLO while busy is ignored
        issue(OP_DIVU, 32'd1000, 32'd33);
        repeat (4) @(negedge clk);
        wr_lo = 1'b1; wd = 32'hDEAD_BEEF;
        #1 check("busy_wr_stall", stall, 1'b1);
        @(negedge clk);
        wr_lo = 1'b0;
        check("busy_wr_ignored", lo, m_lo);
        wait_done(); idle_check();

        // MTHI together with start: write lands, result overwrites later
        wr_hi = 1'b1; wd = 32'h1234_5678; m_hi = wd;
        issue(OP_MULTU, 32'd9, 32'd9);
        wr_hi = 1'b0;
        check("wr_with_start_hi", hi, 32'h1234_5678);
        wait_done(); idle_check();

        // Back-to-back: start during DONE, first result held until second DONE
        issue(OP_MULTU, 32'd100, 32'd200);
        wait_done();
        issue(OP_DIVU, 32'd50000, 32'd7);
        check("b2b_busy", busy, 1'b1);
        check("b2b_hold_hi", hi, m_hi);
        check("b2b_hold_lo", lo, m_lo);
        wait_done(); idle_check();

        // Reset in the middle of a multiply
        wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'd5; m_hi = 32'd5; m_lo = 32'd5;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("preload_hi", hi, 32'd5);
        check("preload_lo", lo, 32'd5);
        issue(OP_MULTU, 32'd7, 32'd6);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_hi = 32'd0; m_lo = 32'd0; busy_cnt = 0;
        check("rst_run_busy", busy, 1'b0);
        check("rst_run_done", done, 1'b0);
        check("rst_run_hi", hi, 32'd0);
        check("rst_run_lo", lo, 32'd0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        check("rst_no_done", done_cnt, d0);

        // Randomized operations, optionally back-to-back, with busy-time pokes
        b2b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic        o;
            logic [31:0] x, y;
            o = 1'($urandom_range(0, 1));
            x = rnd_opnd();
            y = rnd_opnd();
            issue(o, x, y);
            if (busy) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                start = 1'($urandom_range(0, 1));
                op = 1'($urandom_range(0, 1));
                a = $urandom(); b = $urandom(); wd = $urandom();
                wr_hi = 1'($urandom_range(0, 1));
                hilo_rd = ~(start | wr_hi);
                #1 check("rnd_busy_stall", stall, 1'b1);
                @(negedge clk);
                start = 1'b0; wr_hi = 1'b0; hilo_rd = 1'b0;
            end
            wait_done();
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) begin
                idle_check();
                if ($urandom_range(0, 3) == 0) begin
                    wr_lo = 1'b1; wd = $urandom(); m_lo = wd;
                    @(negedge clk);
                    wr_lo = 1'b0;
                    check("rnd_mtlo", lo, m_lo);
                end
            end
        end
        idle_check();
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
